ifmd_conv_seq: RTL
==================

Name: ifmd_conv_seq

Overview:
Sequencer for the 64-entry x 8-bit input-feature-map RAM. It loads an 8x8 feature map from a valid/ready pixel stream into the RAM. It then replays the map as 3x3 sliding windows (stride 1, no padding, 6x6 output positions) toward the MAC datapath, compensating for the RAM's 1-cycle registered read latency. It is the sole driver of the RAM write and read ports.

Parameters:
IMG_W, 8, feature-map width in pixels
IMG_H, 8, feature-map height in pixels
K, 3, kernel side
ADDR_W, 6, RAM address width; IMG_W*IMG_H <= 2^ADDR_W
DATA_W, 8, pixel width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin a job; honoured only in IDLE
reload  in  1  sampled with start: 1 = load new map then convolve, 0 = convolve current RAM contents
in_valid  in  1  input pixel valid
in_data  in  8  input pixel
in_ready  out  1  controller accepts pixel
ram_write  out  1  to RAM write enable
ram_write_addr  out  6  to RAM write address
ram_din  out  8  to RAM write data
ram_read  out  1  to RAM read enable
ram_read_addr  out  6  to RAM read address
ram_dout  in  8  from RAM registered read data
pix_valid  out  1  window pixel valid to MAC
pix_data  out  8  window pixel
win_first  out  1  with pix_valid: first pixel of a window (kr=0, kc=0)
win_last  out  1  with pix_valid: last pixel of a window (kr=K-1, kc=K-1)
out_row  out  3  output row of current pixel's window
out_col  out  3  output column of current pixel's window
busy  out  1  state != IDLE
done  out  1  1-cycle pulse at job end

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters=0; every output 0 (in_ready, ram_write, ram_read, pix_valid, win_first, win_last, done, busy=0; all address/data/row/col outputs=0). RAM contents are not touched.
- States: IDLE, LOAD, CONV, DRAIN, DONE.
- IDLE: start=1 & reload=1 -> LOAD. start=1 & reload=0 -> CONV. Otherwise stay. start is ignored in every other state.
- LOAD: in_ready=1, combinational from state. On in_valid & in_ready:
  - ram_write=1 (combinational), ram_write_addr=load_cnt, ram_din=in_data.
  - load_cnt increments.
  - The accept with load_cnt=IMG_W*IMG_H-1 -> CONV, load_cnt=0.
  - Gaps in in_valid stall the load with no writes.
- in_ready=0 outside LOAD; in_valid is ignored there.
- CONV: ram_read=1 every cycle, combinational. ram_read_addr=(orow+kr)*IMG_W+(ocol+kc).
  - Counter nesting, fastest first: kc, kr, ocol, orow. Each counter wraps at K-1 or IMG-K respectively.
  - Ranges: orow,ocol in 0..5; kr,kc in 0..2.
  - Exactly 324 read cycles per job.
  - The cycle issuing orow=ocol=5, kr=kc=2 -> DRAIN.
- The first read of CONV directly after LOAD is legal: the last write commits on the same edge that enters CONV.
- Output alignment: pix_valid, win_first, win_last, out_row and out_col are registered copies of the read-side ram_read / (kr=0&kc=0) / (kr=K-1&kc=K-1) / orow / ocol, delayed 1 cycle. pix_data=ram_dout, passthrough. pix_valid is high only in the cycle after a read.
- DRAIN: no read; the final pixel is presented. -> DONE.
- DONE: done=1 for one cycle, then -> IDLE.
- The MAC accepts one pixel per cycle with no backpressure.
- Latency: with reload=1 and continuous in_valid, the start edge is followed by 64 LOAD cycles, 324 CONV cycles, 1 DRAIN cycle and 1 DONE cycle.
- rst_n low mid-job: immediate return to IDLE with all outputs 0. A partially loaded RAM is kept as is.

Test Plan:
1. Reset value check: rst_n=0 asserted asynchronously mid-cycle -> all outputs 0 immediately, busy=0.
2. Load then convolve: start, reload=1; stream pixel value = index 0..63 with in_valid held 1.
   - 64 writes at addresses 0..63.
   - First window pix_data = 0,1,2,8,9,10,16,17,18 (win_first on 0, win_last on 18, out_row=out_col=0).
   - Last window = 45,46,47,53,54,55,61,62,63 (out_row=out_col=5).
   - Exactly 324 pix_valid cycles; done pulses 390 cycles after the start edge.
3. Input gaps: drop in_valid every other cycle during LOAD -> still exactly 64 writes with correct addresses; window data identical to scenario 2.
4. Reuse: after scenario 2, start with reload=0 and in_valid=1 -> in_ready stays 0, no RAM writes, same 324-pixel sequence as scenario 2.
5. Start while busy: pulse start during CONV -> ignored; a single done pulse at the normal time.
6. Reset mid-CONV at window (2,3): pulse rst_n low -> outputs 0, IDLE. A following start with reload=0 yields the first window 0,1,2,8,9,10,16,17,18.

Source files
------------

// File: rtl/ifmd_conv_seq_if.sv
// Signal bundle between the IFM convolution sequencer and its surroundings:
// job control, pixel input stream, feature-map RAM ports and MAC window stream.
interface ifmd_conv_seq_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int POS_W  = 3
);
    logic              start;
    logic              reload;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_write_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_read;
    logic [ADDR_W-1:0] ram_read_addr;
    logic [DATA_W-1:0] ram_dout;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              win_first;
    logic              win_last;
    logic [POS_W-1:0]  out_row;
    logic [POS_W-1:0]  out_col;
    logic              busy;
    logic              done;

    modport slave (
        input  start, reload, in_valid, in_data, ram_dout,
        output in_ready, ram_write, ram_write_addr, ram_din,
               ram_read, ram_read_addr,
               pix_valid, pix_data, win_first, win_last, out_row, out_col,
               busy, done
    );

    modport master (
        output start, reload, in_valid, in_data, ram_dout,
        input  in_ready, ram_write, ram_write_addr, ram_din,
               ram_read, ram_read_addr,
               pix_valid, pix_data, win_first, win_last, out_row, out_col,
               busy, done
    );
endinterface

// File: rtl/ifmd_conv_seq.sv
// IFM RAM sequencer: loads a feature map from a valid/ready stream into RAM, then
// replays it as KxK stride-1 windows toward the MAC, hiding the 1-cycle RAM read latency.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting streamed pixels into RAM
// CONV  | issuing one window-pixel read per cycle
// DRAIN | presenting the final pixel of the last window
// DONE  | one-cycle done pulse
module ifmd_conv_seq #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input logic            clk,
    input logic            rst_n,
    ifmd_conv_seq_if.slave bus
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int KW   = $clog2(K);
    localparam int RW   = $clog2(IMG_H - K + 1);
    localparam int CW   = $clog2(IMG_W - K + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] load_cnt;
    logic [KW-1:0]     kc, kr;
    logic [CW-1:0]     ocol;
    logic [RW-1:0]     orow;

    logic in_ready, ram_write, ram_read, busy, done;
    logic load_last, kc_wrap, kr_wrap, ocol_wrap, orow_wrap, conv_last;

    logic [ADDR_W-1:0] row_idx, col_idx, read_addr;
    logic [DATA_W-1:0] ram_din;

    logic          pix_valid_q, win_first_q, win_last_q;
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    assign load_last = (load_cnt == ADDR_W'(NPIX - 1));
    assign kc_wrap   = (kc == KW'(K - 1));
    assign kr_wrap   = (kr == KW'(K - 1));
    assign ocol_wrap = (ocol == CW'(IMG_W - K));
    assign orow_wrap = (orow == RW'(IMG_H - K));
    assign conv_last = orow_wrap & ocol_wrap & kr_wrap & kc_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_nxt = bus.reload ? S_LOAD : S_CONV;
            S_LOAD:  if (ram_write && load_last) state_nxt = S_CONV;
            S_CONV:  if (conv_last) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        ram_read = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            S_IDLE:  busy     = 1'b0;
            S_LOAD:  in_ready = 1'b1;
            S_CONV:  ram_read = 1'b1;
            S_DONE:  done     = 1'b1;
            default: ;
        endcase
        ram_write = in_ready & bus.in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt <= '0;
        end else if (ram_write) begin
            load_cnt <= load_last ? '0 : load_cnt + 1'b1;
        end
    end

    // kc fastest, then kr, ocol, orow; all return to zero after the last read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kc   <= '0;
            kr   <= '0;
            ocol <= '0;
            orow <= '0;
        end else if (ram_read) begin
            kc <= kc_wrap ? '0 : kc + 1'b1;
            if (kc_wrap) begin
                kr <= kr_wrap ? '0 : kr + 1'b1;
                if (kr_wrap) begin
                    ocol <= ocol_wrap ? '0 : ocol + 1'b1;
                    if (ocol_wrap) begin
                        orow <= orow_wrap ? '0 : orow + 1'b1;
                    end
                end
            end
        end
    end

    assign row_idx   = ADDR_W'(orow) + ADDR_W'(kr);
    assign col_idx   = ADDR_W'(ocol) + ADDR_W'(kc);
    assign read_addr = row_idx * ADDR_W'(IMG_W) + col_idx;

    // Window tags ride one cycle behind the read so they line up with ram_dout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid_q <= 1'b0;
            win_first_q <= 1'b0;
            win_last_q  <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            pix_valid_q <= ram_read;
            win_first_q <= ram_read & (kr == '0) & (kc == '0);
            win_last_q  <= ram_read & kr_wrap & kc_wrap;
            out_row_q   <= orow;
            out_col_q   <= ocol;
        end
    end

    assign ram_din = ram_write ? bus.in_data : '0;

    assign bus.in_ready       = in_ready;
    assign bus.ram_write      = ram_write;
    assign bus.ram_write_addr = load_cnt;
    assign bus.ram_din        = ram_din;
    assign bus.ram_read       = ram_read;
    assign bus.ram_read_addr  = read_addr;
    assign bus.pix_valid      = pix_valid_q;
    assign bus.pix_data       = pix_valid_q ? bus.ram_dout : '0;
    assign bus.win_first      = win_first_q;
    assign bus.win_last       = win_last_q;
    assign bus.out_row        = out_row_q;
    assign bus.out_col        = out_col_q;
    assign bus.busy           = busy;
    assign bus.done           = done;
endmodule
